// File: rtl/io_tx_buffer.sv
// Snoops CPU byte writes to the UART port (0x30000) and stop port (0x30004),
// queues them in a FIFO drained to the UART transmitter. Optional: IO_TX_ZERO_FILTER_EN.
module io_tx_buffer #(
  parameter int DEPTH_BIT   = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic [31:0]          mem_a,
  input  logic [7:0]           mem_dout,
  input  logic                 mem_wr,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 io_buffer_full,
  output logic [DEPTH_BIT:0]   count,
  output logic                 overflow,
  output logic                 program_end,
  output logic [1:0]           fsm_state
);

  localparam int DEPTH        = 1 << DEPTH_BIT;
  localparam int FULL_LEVEL_I = DEPTH - FULL_MARGIN;
  localparam logic [DEPTH_BIT:0]   DEPTH_CNT  = {1'b1, {DEPTH_BIT{1'b0}}};
  localparam logic [DEPTH_BIT:0]   FULL_LEVEL = FULL_LEVEL_I[DEPTH_BIT:0];
  localparam logic [DEPTH_BIT:0]   CNT_ONE    = {{DEPTH_BIT{1'b0}}, 1'b1};
  localparam logic [DEPTH_BIT-1:0] PTR_ONE    = {{(DEPTH_BIT-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STOPPING = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  state_t               state;
  logic [7:0]           fifo_mem [DEPTH];
  logic [DEPTH_BIT-1:0] rd_ptr;
  logic [DEPTH_BIT-1:0] wr_ptr;

  logic       io_sel;
  logic       data_wr;
  logic       stop_wr;
  logic       data_ok;
  logic       push_req;
  logic       push;
  logic       pop;
  logic       drop;
  logic       fifo_full;
  logic [7:0] push_byte;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^{mem_a[31:18], mem_a[15:3]};

  // Address decode: only bits 17:16 and 2:0 select the I/O ports.
  assign io_sel  = rdy_in & mem_wr & (mem_a[17:16] == 2'b11);
  assign data_wr = io_sel & (mem_a[2:0] == 3'b000);
  assign stop_wr = io_sel & (mem_a[2:0] == 3'b100);

`ifdef IO_TX_ZERO_FILTER_EN
  assign data_ok = data_wr & (mem_dout != 8'h00);
`else
  assign data_ok = data_wr;
`endif

  // Transmit handshake: a byte transfers on an edge where tx_valid & tx_ready;
  // tx_data holds the FIFO head and stays stable while tx_valid & !tx_ready.
  assign tx_valid       = (count != '0);
  assign tx_data        = fifo_mem[rd_ptr];
  assign io_buffer_full = (count >= FULL_LEVEL);
  assign fsm_state      = state;

  assign fifo_full = (count == DEPTH_CNT);
  assign pop       = tx_valid & tx_ready;
  assign push_req  = (state == ST_RUN) & (data_ok | stop_wr);
  // A simultaneous pop frees the slot, so a push while full is only dropped without one.
  assign push      = push_req & (~fifo_full | pop);
  assign drop      = push_req & fifo_full & ~pop;
  assign push_byte = stop_wr ? 8'h00 : mem_dout;

  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_byte;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      program_end <= 1'b0;
      state       <= ST_RUN;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
      case (state)
        ST_RUN: begin
          if (stop_wr) begin
            state <= ST_STOPPING;
          end
        end
        // Registered count reaching zero means the terminator has already left.
        ST_STOPPING: begin
          if (count == '0) begin
            state       <= ST_DONE;
            program_end <= 1'b1;
          end
        end
        ST_DONE: begin
          program_end <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_tx_buffer.sv
// Self-checking bench for io_tx_buffer: expected bytes queue on capture and
// are compared as the transmitter pops them.
module tb_io_tx_buffer;

  localparam logic [31:0] UART_ADDR = 32'h0003_0000;
  localparam logic [31:0] STOP_ADDR = 32'h0003_0004;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        io_buffer_full;
  logic [4:0]  count;
  logic        overflow;
  logic        program_end;
  logic [1:0]  fsm_state;

  logic [7:0]  exp_q[$];
  int          n_checks;
  int          n_errors;
  int          base_cnt;

  io_tx_buffer dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .io_buffer_full (io_buffer_full),
    .count          (count),
    .overflow       (overflow),
    .program_end    (program_end),
    .fsm_state      (fsm_state)
  );

  // Clock and watchdog
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every handshake pops the oldest expected byte.
  always @(negedge clk_in) begin
    if (!rst_in && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        check("tx_spurious", 32'(tx_valid), 32'd0);
      end else begin
        check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic bus_access(input logic [31:0] addr, input logic [7:0] data, input logic wr);
    mem_a    = addr;
    mem_dout = data;
    mem_wr   = wr;
    @(posedge clk_in);
    #1;
    mem_wr   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_in   = 1'b1;
    mem_wr   = 1'b0;
    tx_ready = 1'b0;
    rdy_in   = 1'b1;
    idle(1);
    rst_in   = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string tag);
    tx_ready = 1'b1;
    for (int i = 0; i < 64 && count != 5'd0; i++) begin
      idle(1);
    end
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_in   = 1'b1;
    rdy_in   = 1'b1;
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    tx_ready = 1'b0;
    idle(2);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_full", 32'(io_buffer_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_pend", 32'(program_end), 32'd0);
    rst_in = 1'b0;

    // Basic order
    tx_ready = 1'b1;
    exp_q.push_back(8'h41);
    bus_access(UART_ADDR, 8'h41, 1'b1);
    check("first_valid", 32'(tx_valid), 32'd1);
    check("first_data", 32'(tx_data), 32'h41);
    exp_q.push_back(8'h42);
    bus_access(UART_ADDR, 8'h42, 1'b1);
    exp_q.push_back(8'h43);
    bus_access(UART_ADDR, 8'h43, 1'b1);
    drain("basic");

    // Back-pressure: 17 pushes into 16 slots, the last is lost
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(8'h10 + i));
      bus_access(UART_ADDR, 8'(8'h10 + i), 1'b1);
      check("bp_count", 32'(count), (i < 16) ? 32'(i + 1) : 32'd16);
      check("bp_full", 32'(io_buffer_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
    end
    check("bp_ovf", 32'(overflow), 32'd1);
    drain("bp");

    // Push and pop together while full is not a drop
    do_reset();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(8'h80 + i));
      bus_access(UART_ADDR, 8'(8'h80 + i), 1'b1);
    end
    tx_ready = 1'b1;
    exp_q.push_back(8'hC5);
    bus_access(UART_ADDR, 8'hC5, 1'b1);
    check("fullpp_count", 32'(count), 32'd16);
    check("fullpp_ovf", 32'(overflow), 32'd0);
    drain("fullpp");

    // Wrap-around with simultaneous push/pop
    tx_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(1, 255));
      exp_q.push_back(d);
      bus_access(UART_ADDR, d, 1'b1);
      check("wrap_count", 32'(count <= 5'd1), 32'd1);
    end
    drain("wrap");

    // Stop sequence
    tx_ready = 1'b0;
    exp_q.push_back(8'h68);
    bus_access(UART_ADDR, 8'h68, 1'b1);
    exp_q.push_back(8'h69);
    bus_access(UART_ADDR, 8'h69, 1'b1);
    exp_q.push_back(8'h00);
    bus_access(STOP_ADDR, 8'hAB, 1'b1);
    check("stop_count", 32'(count), 32'd3);
    check("stop_state", 32'(fsm_state), 32'd1);
    tx_ready = 1'b1;
    idle(3);
    check("stop_drained", 32'(count), 32'd0);
    check("pend_early", 32'(program_end), 32'd0);
    idle(1);
    check("pend_set", 32'(program_end), 32'd1);
    check("done_state", 32'(fsm_state), 32'd2);
    check("stop_left", 32'(exp_q.size()), 32'd0);
    bus_access(UART_ADDR, 8'h77, 1'b1);
    check("done_ignored", 32'(count), 32'd0);
    check("done_valid", 32'(tx_valid), 32'd0);
    check("pend_sticky", 32'(program_end), 32'd1);

    // Zero filter, decode and capture gating
    do_reset();
`ifdef IO_TX_ZERO_FILTER_EN
    base_cnt = 0;
`else
    base_cnt = 1;
    exp_q.push_back(8'h00);
`endif
    bus_access(UART_ADDR, 8'h00, 1'b1);
    check("zero_count", 32'(count), 32'(base_cnt));
    check("zero_ovf", 32'(overflow), 32'd0);
    rdy_in = 1'b0;
    bus_access(UART_ADDR, 8'h55, 1'b1);
    check("gate_count", 32'(count), 32'(base_cnt));
    rdy_in = 1'b1;
    bus_access(32'h0003_0001, 8'h56, 1'b1);
    check("dec_low", 32'(count), 32'(base_cnt));
    bus_access(32'h0002_0000, 8'h57, 1'b1);
    check("dec_high", 32'(count), 32'(base_cnt));
    bus_access(UART_ADDR, 8'h58, 1'b0);
    check("dec_read", 32'(count), 32'(base_cnt));
    exp_q.push_back(8'h5A);
    bus_access(UART_ADDR, 8'h5A, 1'b1);
    rdy_in = 1'b0;
    drain("gate_tx");
    rdy_in = 1'b1;

    // Reset mid-drain
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'(8'hA0 + i));
      bus_access(UART_ADDR, 8'(8'hA0 + i), 1'b1);
    end
    check("mid_count", 32'(count), 32'd5);
    exp_q.delete();
    rst_in = 1'b1;
    idle(1);
    rst_in = 1'b0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_full", 32'(io_buffer_full), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_pend", 32'(program_end), 32'd0);
    idle(2);
    check("mid_rst_hold", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
